// File: rtl/primary_ray_gen_if.sv
// Pixel-in / ray-out bundle between the thread generator, the ray generator and the ray core.
// The slave side is the ray generator; the master side drives pixels and consumes rays.
interface primary_ray_gen_if #(
  parameter int DIR_W = 24
);
  logic [9:0]              pix_x;
  logic [9:0]              pix_y;
  logic                    pix_valid;
  logic                    ray_core_free;
  logic                    ray_valid;
  logic                    ray_ready;
  logic signed [DIR_W-1:0] ray_dir_x;
  logic signed [DIR_W-1:0] ray_dir_y;
  logic signed [DIR_W-1:0] ray_dir_z;
  logic [9:0]              ray_px;
  logic [9:0]              ray_py;
  logic                    ray_sof;
  logic                    coord_err;

  modport slave (
    input  pix_x, pix_y, pix_valid, ray_ready,
    output ray_core_free, ray_valid, ray_dir_x, ray_dir_y, ray_dir_z,
           ray_px, ray_py, ray_sof, coord_err
  );

  modport master (
    output pix_x, pix_y, pix_valid, ray_ready,
    input  ray_core_free, ray_valid, ray_dir_x, ray_dir_y, ray_dir_z,
           ray_px, ray_py, ray_sof, coord_err
  );
endinterface

// File: rtl/primary_ray_gen.sv
// Turns each screen pixel into a fixed-point primary camera ray through a 2-stage
// pipeline and an output FIFO, and issues the credit that throttles the pixel source.
module primary_ray_gen #(
  parameter int          WIDTH     = 640,
  parameter int          HEIGHT    = 480,
  parameter logic [15:0] PIX_SCALE = 16'd256,
  parameter int          SHIFT     = 4,
  parameter int          FOCAL     = 4096,
  parameter int          DIR_W     = 24,
  parameter int          DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  primary_ray_gen_if.slave   bus
);

  localparam int PROD_W = 28;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int OCC_W  = $clog2(DEPTH + 2) + 2;

  localparam logic signed [PROD_W-1:0] SCALE_S = PROD_W'($signed({1'b0, PIX_SCALE}));
  localparam logic signed [DIR_W-1:0]  FOCAL_S = DIR_W'(FOCAL);

  typedef struct packed {
    logic signed [DIR_W-1:0] dirX;
    logic signed [DIR_W-1:0] dirY;
    logic [9:0]              px;
    logic [9:0]              py;
    logic                    sof;
  } ray_t;

  logic                    s1Valid_q;
  logic signed [11:0]      s1Dx_q, s1Dy_q;
  logic [9:0]              s1Px_q, s1Py_q;
  logic                    s1Sof_q;

  logic                    s2Valid_q;
  ray_t                    s2Ray_q;

  ray_t                    mem_q [DEPTH];
  logic [PTR_W-1:0]        wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic                    free_q;
  logic                    coordErr_q, coordErr_d;
  logic signed [DIR_W-1:0] dirZ_q;

  logic                    inRange, accept, pop, full, pushOk, overflow;
  logic signed [11:0]      dx_d, dy_d;
  logic signed [PROD_W-1:0] prodX, prodY, shX, shY;

  assign inRange = ({1'b0, bus.pix_x} < 11'(WIDTH)) && ({1'b0, bus.pix_y} < 11'(HEIGHT));
  assign accept  = bus.pix_valid && inRange;

  // Centre the pixel: odd offsets from the screen middle, y flipped so row 0 is the top.
  assign dx_d = $signed({1'b0, bus.pix_x, 1'b1}) - $signed(12'(WIDTH));
  assign dy_d = $signed(12'(HEIGHT - 1)) - $signed({1'b0, bus.pix_y, 1'b0});

  assign prodX = PROD_W'(s1Dx_q) * SCALE_S;
  assign prodY = PROD_W'(s1Dy_q) * SCALE_S;
  assign shX   = prodX >>> SHIFT;
  assign shY   = prodY >>> SHIFT;

  assign pop      = (count_q != '0) && bus.ray_ready;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pushOk   = s2Valid_q && (!full || pop);
  assign overflow = s2Valid_q && full && !pop;

  assign count_d    = count_q + CNT_W'(pushOk) - CNT_W'(pop);
  assign occ_d      = occ_q + OCC_W'(accept) - OCC_W'(pop);
  assign coordErr_d = coordErr_q | (bus.pix_valid && !inRange) | overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Dx_q     <= '0;
      s1Dy_q     <= '0;
      s1Px_q     <= '0;
      s1Py_q     <= '0;
      s1Sof_q    <= 1'b0;
      s2Valid_q  <= 1'b0;
      s2Ray_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      occ_q      <= '0;
      free_q     <= 1'b0;
      coordErr_q <= 1'b0;
      dirZ_q     <= '0;
    end else begin
      s1Valid_q <= accept;
      if (accept) begin
        s1Dx_q  <= dx_d;
        s1Dy_q  <= dy_d;
        s1Px_q  <= bus.pix_x;
        s1Py_q  <= bus.pix_y;
        s1Sof_q <= (bus.pix_x == 10'd0) && (bus.pix_y == 10'd0);
      end

      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Ray_q.dirX <= DIR_W'(shX);
        s2Ray_q.dirY <= DIR_W'(shY);
        s2Ray_q.px   <= s1Px_q;
        s2Ray_q.py   <= s1Py_q;
        s2Ray_q.sof  <= s1Sof_q;
      end

      // A push into a full FIFO is only legal when the head leaves in the same cycle.
      if (pushOk) begin
        mem_q[wrPtr_q] <= s2Ray_q;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;

      count_q    <= count_d;
      occ_q      <= occ_d;
      free_q     <= (occ_d <= OCC_W'(DEPTH - 2));
      coordErr_q <= coordErr_d;
      dirZ_q     <= FOCAL_S;
    end
  end

  assign bus.ray_valid     = (count_q != '0);
  assign bus.ray_dir_x     = mem_q[rdPtr_q].dirX;
  assign bus.ray_dir_y     = mem_q[rdPtr_q].dirY;
  assign bus.ray_dir_z     = dirZ_q;
  assign bus.ray_px        = mem_q[rdPtr_q].px;
  assign bus.ray_py        = mem_q[rdPtr_q].py;
  assign bus.ray_sof       = mem_q[rdPtr_q].sof;
  assign bus.ray_core_free = free_q;
  assign bus.coord_err     = coordErr_q;

endmodule
